// File: rtl/mms.sv
// Dual-port 1024x16 word memory with registered instruction, immediate and
// port-2 read outputs. Reads return pre-write data, and port 2 wins a write collision.
module mms (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        w1,
  input  logic        w2,
  input  logic        r1,
  input  logic        r2,
  input  logic        Memsrc,
  input  logic [15:0] a1,
  input  logic [15:0] a2_0,
  input  logic [15:0] a2_1,
  input  logic [15:0] write2,
  output logic [15:0] IR,
  output logic [15:0] ImR,
  output logic [15:0] Memout
);

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AW    = 10;

  // Storage has no reset, so reset leaves the contents alone; it starts out all-zero.
  logic [15:0] mem_q [DEPTH] = '{default: '0};

  logic [15:0]   a2;
  logic [AW-1:0] p1_addr;
  logic [AW-1:0] p2_addr;
  logic          p1_we;
  logic          p2_we;
  logic [15:0]   p1_rdata;
  logic [15:0]   p2_rdata;

  logic [15:0] ir_d, ir_q;
  logic [15:0] imr_d, imr_q;
  logic [15:0] memout_d, memout_q;

  // Upper address bits are ignored, so addresses alias modulo the depth.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{a1[15:AW], a2[15:AW]};

  always_comb begin
    a2       = Memsrc ? a2_1 : a2_0;
    p1_addr  = a1[AW-1:0];
    p2_addr  = a2[AW-1:0];
    p1_we    = w1 && rst_n;
    p2_we    = w2 && rst_n;
    p1_rdata = mem_q[p1_addr];
    p2_rdata = mem_q[p2_addr];
  end

  // The port-2 write comes second, so it overrides port 1 on the same word.
  always_ff @(posedge clk) begin
    if (p1_we) mem_q[p1_addr] <= write2;
    if (p2_we) mem_q[p2_addr] <= write2;
  end

  always_comb begin
    ir_d     = r1 ? p1_rdata : ir_q;
    imr_d    = r2 ? p2_rdata : imr_q;
    memout_d = p2_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q     <= '0;
      imr_q    <= '0;
      memout_q <= '0;
    end else begin
      ir_q     <= ir_d;
      imr_q    <= imr_d;
      memout_q <= memout_d;
    end
  end

  assign IR     = ir_q;
  assign ImR    = imr_q;
  assign Memout = memout_q;

endmodule

// File: tb/tb_mms.sv
// Randomized and directed bench for mms against an array-based reference model.
module tb_mms;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        w1, w2, r1, r2, Memsrc;
  logic [15:0] a1, a2_0, a2_1, write2;
  logic [15:0] IR, ImR, Memout;

  mms dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .w1     (w1),
    .w2     (w2),
    .r1     (r1),
    .r2     (r2),
    .Memsrc (Memsrc),
    .a1     (a1),
    .a2_0   (a2_0),
    .a2_1   (a2_1),
    .write2 (write2),
    .IR     (IR),
    .ImR    (ImR),
    .Memout (Memout)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  int unsigned ref_mem [1024];
  int unsigned exp_ir, exp_imr, exp_mo;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare outputs.
  task automatic cycle(input logic i_w1, input logic i_w2, input logic i_r1, input logic i_r2,
                       input logic i_ms, input int unsigned i_a1, input int unsigned i_a20,
                       input int unsigned i_a21, input int unsigned i_d);
    int unsigned ea1, ea2, old1, old2;
    w1 = i_w1; w2 = i_w2; r1 = i_r1; r2 = i_r2; Memsrc = i_ms;
    a1 = i_a1[15:0]; a2_0 = i_a20[15:0]; a2_1 = i_a21[15:0]; write2 = i_d[15:0];
    @(posedge clk);
    ea1  = (i_a1 % 65536) % 1024;
    ea2  = ((i_ms ? i_a21 : i_a20) % 65536) % 1024;
    old1 = ref_mem[ea1];
    old2 = ref_mem[ea2];
    if (rst_n) begin
      exp_mo = old2;
      if (i_r1) exp_ir = old1;
      if (i_r2) exp_imr = old2;
      if (i_w1) ref_mem[ea1] = i_d % 65536;
      if (i_w2) ref_mem[ea2] = i_d % 65536;
    end else begin
      exp_ir = 0; exp_imr = 0; exp_mo = 0;
    end
    #1;
    check_eq("IR", IR, exp_ir[15:0]);
    check_eq("ImR", ImR, exp_imr[15:0]);
    check_eq("Memout", Memout, exp_mo[15:0]);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 0;
    exp_ir = 0; exp_imr = 0; exp_mo = 0;
    rst_n = 1'b0;
    w1 = 0; w2 = 0; r1 = 0; r2 = 0; Memsrc = 0;
    a1 = '0; a2_0 = '0; a2_1 = '0; write2 = '0;
    #2;
    check_eq("rst_IR", IR, 16'h0000);
    check_eq("rst_ImR", ImR, 16'h0000);
    check_eq("rst_Memout", Memout, 16'h0000);
    // Writes attempted under reset must be dropped.
    cycle(1, 1, 1, 1, 0, 40, 41, 0, 16'hDEAD);
    rst_n = 1'b1;
    cycle(0, 0, 1, 1, 0, 40, 41, 0, 0);
    check_eq("rst_blocked_wr", IR, 16'h0000);

    // Fill then read back.
    for (int i = 0; i < 100; i++) cycle(0, 1, 0, 0, 0, 0, i, 0, i);
    for (int i = 0; i < 100; i++) begin
      cycle(0, 0, 1, 1, 0, i, i, 0, 0);
      check_eq("fill_IR", IR, 16'(i));
      check_eq("fill_Memout", Memout, 16'(i));
    end

    // Port-2 address select.
    cycle(0, 1, 0, 0, 0, 0, 5, 0, 16'h1234);
    cycle(0, 1, 0, 0, 0, 0, 9, 0, 16'hABCD);
    cycle(0, 0, 0, 0, 1, 0, 5, 9, 0);
    check_eq("sel_1", Memout, 16'hABCD);
    cycle(0, 0, 0, 0, 0, 0, 5, 9, 0);
    check_eq("sel_0", Memout, 16'h1234);

    // Load-enable hold.
    cycle(0, 1, 0, 0, 0, 0, 20, 0, 16'h0007);
    cycle(0, 1, 0, 0, 0, 0, 21, 0, 16'h0008);
    cycle(0, 0, 1, 1, 0, 20, 20, 0, 0);
    cycle(0, 0, 0, 0, 0, 21, 21, 0, 0);
    check_eq("hold_IR", IR, 16'h0007);
    check_eq("hold_ImR", ImR, 16'h0007);
    check_eq("hold_Memout", Memout, 16'h0008);

    // Collision with read-first.
    cycle(0, 1, 0, 0, 0, 0, 3, 0, 16'h0011);
    cycle(1, 1, 1, 1, 0, 3, 3, 0, 16'h00FF);
    check_eq("coll_old_IR", IR, 16'h0011);
    check_eq("coll_old_Memout", Memout, 16'h0011);
    cycle(0, 0, 1, 1, 0, 3, 3, 0, 0);
    check_eq("coll_new_IR", IR, 16'h00FF);

    // Asynchronous reset between edges; memory survives.
    cycle(0, 1, 0, 0, 0, 0, 7, 0, 16'h0070);
    cycle(0, 0, 1, 1, 0, 7, 7, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    exp_ir = 0; exp_imr = 0; exp_mo = 0;
    check_eq("async_IR", IR, 16'h0000);
    check_eq("async_ImR", ImR, 16'h0000);
    check_eq("async_Memout", Memout, 16'h0000);
    cycle(0, 1, 1, 1, 0, 7, 7, 0, 16'hBEEF);
    rst_n = 1'b1;
    cycle(0, 0, 1, 1, 0, 7, 7, 0, 0);
    check_eq("post_rst_IR", IR, 16'h0070);

    // Aliasing of upper address bits.
    cycle(0, 1, 0, 0, 0, 0, 16'h0402, 0, 16'h5555);
    cycle(0, 0, 1, 1, 1, 16'h0002, 0, 16'h0002, 0);
    check_eq("alias_IR", IR, 16'h5555);
    check_eq("alias_ImR", ImR, 16'h5555);

    // Random traffic, narrow address range to provoke collisions and aliasing.
    for (int k = 0; k < 2000; k++) begin
      int unsigned hi1, hi2, hi3;
      hi1 = $urandom_range(0, 63) * 1024;
      hi2 = $urandom_range(0, 63) * 1024;
      hi3 = $urandom_range(0, 63) * 1024;
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        #1;
        exp_ir = 0; exp_imr = 0; exp_mo = 0;
        check_eq("rnd_async_IR", IR, 16'h0000);
      end else begin
        rst_n = 1'b1;
      end
      cycle($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 1),
            hi1 + $urandom_range(0, 15), hi2 + $urandom_range(0, 15),
            hi3 + $urandom_range(0, 15), $urandom_range(0, 65535));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mms.md
MMS -- requirements
Module: mms

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous, active-low.
REQ-003 w1  in  1  port-1 write enable.
REQ-004 w2  in  1  port-2 write enable.
REQ-005 r1  in  1  instruction-register load enable (port 1 read).
REQ-006 r2  in  1  immediate-register load enable (port 2 read).
REQ-007 Memsrc  in  1  port-2 address select: 0 selects a2_0, 1 selects a2_1.
REQ-008 a1  in  16  port-1 word address.
REQ-009 a2_0  in  16  port-2 address, source 0.
REQ-010 a2_1  in  16  port-2 address, source 1.
REQ-011 write2  in  16  write data, shared by both ports.
REQ-012 IR  out  16  instruction register.
REQ-013 ImR  out  16  immediate register.
REQ-014 Memout  out  16  port-2 registered read data.

Function
REQ-015 Storage SHALL be 1024 x 16-bit words, shared by both ports.
- Word address = address bits [9:0]; bits [15:10] are ignored, so addresses alias modulo 1024.
REQ-016 The effective port-2 address SHALL be A2 = Memsrc ? a2_1 : a2_0 (combinational mux).
REQ-017 Port-2 write: w2=1 at a rising edge SHALL store write2 into mem[A2].
REQ-018 Port-1 write: w1=1 at a rising edge SHALL store write2 into mem[a1].
REQ-019 Write collision: if w1 and w2 are both 1 and both target the same word, the port-2 write SHALL win.
REQ-020 IR: r1=1 at a rising edge SHALL load IR with mem[a1]; with r1=0, IR SHALL hold its value.
REQ-021 ImR: r2=1 at a rising edge SHALL load ImR with mem[A2]; with r2=0, ImR SHALL hold its value.
REQ-022 Memout SHALL load mem[A2] on every rising edge, regardless of r2.
REQ-023 Read latency SHALL be one cycle: an address applied before edge N appears on the outputs after edge N.
REQ-024 Read-during-write to the same word on the same edge SHALL return the old (pre-write) data (read-first) on IR, ImR and Memout.
REQ-025 All outputs SHALL be driven directly from registers, with no combinational path from inputs to outputs.

Reset
REQ-026 rst_n=0 SHALL immediately (asynchronously) clear IR, ImR and Memout to 16'h0000, and hold them cleared while low.
REQ-027 Reset SHALL NOT alter memory contents.
- Memory SHALL be zero at power-up/simulation start.
- Writes SHALL be blocked while rst_n=0.
REQ-028 Reset deassertion SHALL take effect at the next rising edge.
- If reset is asserted mid-operation, a write in progress at the same edge SHALL NOT occur.

Verification
REQ-029 Fill then read back:
- Stimulus: w2=1, Memsrc=0, write mem[i]=i for i=0..99 via a2_0/write2; then r1=r2=1, sweep a1=a2_0=i.
- Response: one cycle later IR=i, ImR=i, Memout=i for every i.
REQ-030 Port-2 address select:
- Stimulus: mem[5]=16'h1234, mem[9]=16'hABCD; a2_0=5, a2_1=9, Memsrc=1.
- Response: next edge Memout=16'hABCD; with Memsrc=0, Memout=16'h1234.
REQ-031 Load-enable hold:
- Stimulus: load IR=16'h0007 with r1=1, then set r1=0 and change a1 to an address holding 16'h0008.
- Response: IR stays 16'h0007; ImR behaves the same way with r2; Memout still follows A2 every cycle.
REQ-032 Collision:
- Stimulus: w1=w2=1, a1=A2=3, write2=16'h00FF.
- Response: mem[3]=16'h00FF.
- Stimulus: same edge read of address 3, prior content 16'h0011.
- Response: read returns 16'h0011; the next edge returns 16'h00FF.
REQ-033 Asynchronous reset:
- Stimulus: rst_n=0 between clock edges.
- Response: IR=ImR=Memout=0 immediately.
- After release, reading address 7 (previously written 16'h0070) returns 16'h0070.
REQ-034 Aliasing:
- Stimulus: write 16'h5555 at address 16'h0402.
- Response: reading address 16'h0002 returns 16'h5555.
